// File: rtl/tapped_delay_line_pkg.sv
// Shared mode encodings and elaboration-time helpers for the tapped delay line.
// Pure constants and functions: no latency and no flow control.
package tapped_delay_line_pkg;

  localparam logic MODE_TRANSPORT = 1'b0;
  localparam logic MODE_INERTIAL  = 1'b1;

  // Stage index inside the shift line that feeds tap k.
  function automatic int tap_stage(input int k, input int tap_cycles);
    return (k + 1) * tap_cycles - 1;
  endfunction

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/tapped_delay_line_if.sv
// Control inputs and tap/strobe outputs of the tapped delay line.
// Plain wires: no latency of its own, no backpressure (EN freezes the line).
interface tapped_delay_line_if
  import tapped_delay_line_pkg::*;
#(
  parameter int CHANNELS = 1,
  parameter int TAPS     = 5
);
  logic                       EN;
  logic                       FLUSH;
  logic                       MODE;
  logic [CHANNELS-1:0]        IN;
  logic [CHANNELS*TAPS-1:0]   TAP;
  logic [CHANNELS*TAPS-1:0]   RISE;
  logic [CHANNELS*TAPS-1:0]   FALL;
  logic [CHANNELS-1:0]        ACTIVE;

  modport master (
    output EN, FLUSH, MODE, IN,
    input  TAP, RISE, FALL, ACTIVE
  );

  modport slave (
    input  EN, FLUSH, MODE, IN,
    output TAP, RISE, FALL, ACTIVE
  );
endinterface

// File: rtl/tapped_delay_line_tdl_channel.sv
// One delay channel: optional glitch filter, shift line, taps, edge strobes, ACTIVE.
// Tap k lags IN by (k+1)*TAP_CYCLES cycles (+FILTER_CYCLES in inertial mode); EN low freezes.
module tdl_channel
  import tapped_delay_line_pkg::*;
#(
  parameter int TAPS          = 5,
  parameter int TAP_CYCLES    = 5,
  parameter int FILTER_CYCLES = 3
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            en_i,
  input  logic            flush_i,
  input  logic            mode_i,
  input  logic            in_i,
  input  logic            adv_i,
  output logic [TAPS-1:0] tap_o,
  output logic [TAPS-1:0] rise_o,
  output logic [TAPS-1:0] fall_o,
  output logic            active_o
);

  localparam int D  = TAPS * TAP_CYCLES + 1;
  localparam int CW = clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [D-1:0]  s_q, s_d;
  logic          f_q, f_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          line_in;

  always_comb begin
    s_d     = s_q;
    f_d     = f_q;
    cnt_d   = cnt_q;
    line_in = (mode_i == MODE_INERTIAL) ? f_q : in_i;
    if (flush_i) begin
      s_d   = '0;
      f_d   = 1'b0;
      cnt_d = '0;
    end else if (en_i) begin
      s_d = {s_q[D-2:0], line_in};
      // Tracking IN in transport mode keeps a later switch to inertial glitch-free.
      if (mode_i == MODE_TRANSPORT) begin
        f_d   = in_i;
        cnt_d = '0;
      end else if (in_i == f_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        f_d   = in_i;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s_q   <= '0;
      f_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    localparam int J = tap_stage(k, TAP_CYCLES);
    // s[J+1] still holds the pre-shift tap value, so the pair exposes the edge just taken.
    assign tap_o[k]  = s_q[J];
    assign rise_o[k] = adv_i &  s_q[J] & ~s_q[J+1];
    assign fall_o[k] = adv_i & ~s_q[J] &  s_q[J+1];
  end

  assign active_o = (|s_q) & ~(&s_q);

endmodule

// File: rtl/tapped_delay_line.sv
// Multi-channel tapped delay line with transport/inertial modes and per-tap edge strobes.
// Tap k lags IN by (k+1)*TAP_CYCLES cycles; no backpressure, EN low freezes all state.
module tapped_delay_line
  import tapped_delay_line_pkg::*;
#(
  parameter int CHANNELS      = 1,
  parameter int TAPS          = 5,
  parameter int TAP_CYCLES    = 5,
  parameter int FILTER_CYCLES = 3
) (
  input logic                clk,
  input logic                reset_n,
  tapped_delay_line_if.slave bus
);

  logic adv_q, adv_d;

  // Strobes are only valid in the cycle after a real shift.
  assign adv_d = bus.EN & ~bus.FLUSH;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adv_q <= 1'b0;
    end else begin
      adv_q <= adv_d;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    tdl_channel #(
      .TAPS          (TAPS),
      .TAP_CYCLES    (TAP_CYCLES),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_ch (
      .clk_i    (clk),
      .rst_n_i  (reset_n),
      .en_i     (bus.EN),
      .flush_i  (bus.FLUSH),
      .mode_i   (bus.MODE),
      .in_i     (bus.IN[ch]),
      .adv_i    (adv_q),
      .tap_o    (bus.TAP[ch*TAPS +: TAPS]),
      .rise_o   (bus.RISE[ch*TAPS +: TAPS]),
      .fall_o   (bus.FALL[ch*TAPS +: TAPS]),
      .active_o (bus.ACTIVE[ch])
    );
  end

endmodule

// File: tb/tb_tapped_delay_line.sv
// Bench for tapped_delay_line: directed scenarios plus randomized traffic against a line-history model.
module tb_tapped_delay_line;
  import tapped_delay_line_pkg::*;

  localparam int CH = 2, TP = 5, TC = 5, FC = 3;
  localparam int D  = TP * TC + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  tapped_delay_line_if #(.CHANNELS(CH), .TAPS(TP)) bus ();
  tapped_delay_line_if #(.CHANNELS(1),  .TAPS(1))  bus_m ();

  tapped_delay_line #(.CHANNELS(CH), .TAPS(TP), .TAP_CYCLES(TC), .FILTER_CYCLES(FC)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  tapped_delay_line #(.CHANNELS(1), .TAPS(1), .TAP_CYCLES(1), .FILTER_CYCLES(FC)) dut_m (
    .clk(clk), .reset_n(reset_n), .bus(bus_m)
  );

  int checks = 0;
  int errors = 0;

  // Model: log of values entering the line, one entry per enabled shift since the last clear.
  logic [CH-1:0]    lin[$];
  logic [CH-1:0]    m_f;
  int               m_run[CH];
  logic             m_adv;
  logic [CH*TP-1:0] m_tap, m_rise, m_fall;
  logic [CH-1:0]    m_act;

  function automatic logic stg(input int c, input int j);
    if (j >= lin.size()) return 1'b0;
    return lin[lin.size()-1-j][c];
  endfunction

  task automatic model_outputs();
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < TP; k++) begin
        m_tap[c*TP+k]  = stg(c, (k+1)*TC-1);
        m_rise[c*TP+k] = m_adv &  stg(c, (k+1)*TC-1) & ~stg(c, (k+1)*TC);
        m_fall[c*TP+k] = m_adv & ~stg(c, (k+1)*TC-1) &  stg(c, (k+1)*TC);
      end
      m_act[c] = 1'b0;
      for (int j = 1; j < D; j++) if (stg(c, j) != stg(c, 0)) m_act[c] = 1'b1;
    end
  endtask

  task automatic model_reset();
    lin.delete();
    m_f = '0;
    for (int c = 0; c < CH; c++) m_run[c] = 0;
    m_adv = 1'b0;
    model_outputs();
  endtask

  task automatic model_edge();
    logic [CH-1:0] li;
    if (!reset_n) return;
    if (bus.FLUSH) begin
      lin.delete();
      m_f = '0;
      for (int c = 0; c < CH; c++) m_run[c] = 0;
      m_adv = 1'b0;
    end else if (bus.EN) begin
      for (int c = 0; c < CH; c++) begin
        li[c] = bus.MODE ? m_f[c] : bus.IN[c];
        if (!bus.MODE) begin
          m_f[c] = bus.IN[c];
          m_run[c] = 0;
        end else if (bus.IN[c] == m_f[c]) begin
          m_run[c] = 0;
        end else begin
          m_run[c]++;
          if (m_run[c] == FC) begin
            m_f[c] = bus.IN[c];
            m_run[c] = 0;
          end
        end
      end
      lin.push_back(li);
      m_adv = 1'b1;
    end else begin
      m_adv = 1'b0;
    end
    model_outputs();
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic flush_all();
    bus.IN = '0; bus.EN = 1'b1; bus.FLUSH = 1'b1; bus.MODE = MODE_TRANSPORT;
    cyc();
    bus.FLUSH = 1'b0;
  endtask

  task automatic test_reset();
    bus.EN = 1'b1; bus.FLUSH = 1'b0; bus.MODE = MODE_TRANSPORT; bus.IN = '1;
    bus_m.EN = 1'b1; bus_m.FLUSH = 1'b0; bus_m.MODE = MODE_TRANSPORT; bus_m.IN = 1'b1;
    model_reset();
    repeat (3) cyc();
    checks++;
    if ({bus.TAP, bus.RISE, bus.FALL, bus.ACTIVE} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h required 0", {bus.TAP, bus.RISE, bus.FALL, bus.ACTIVE});
    end
    checks++;
    if ({bus_m.TAP, bus_m.RISE, bus_m.FALL, bus_m.ACTIVE} !== 4'b0) begin
      errors++; $display("FAIL reset_outputs_min got %b required 0", {bus_m.TAP, bus_m.RISE, bus_m.FALL, bus_m.ACTIVE});
    end
    bus.IN = '0; bus_m.IN = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_transport();
    for (int e = 1; e <= 40; e++) begin
      bus.IN = {1'b0, (e >= 10) ? 1'b1 : 1'b0};
      cyc();
      checks++;
      if (bus.TAP[0] !== (e >= 14) || bus.TAP[4] !== (e >= 34) || bus.RISE[0] !== (e == 14)) begin
        errors++; $display("FAIL transport_edges e=%0d tap0=%b tap4=%b rise0=%b", e, bus.TAP[0], bus.TAP[4], bus.RISE[0]);
      end
      checks++;
      if (bus.TAP[9:5] !== 5'b0) begin
        errors++; $display("FAIL transport_ch1 e=%0d got %b required 0", e, bus.TAP[9:5]);
      end
      checks++;
      if ({bus.TAP, bus.RISE, bus.FALL, bus.ACTIVE} !== {m_tap, m_rise, m_fall, m_act}) begin
        errors++; $display("FAIL transport_model e=%0d got %h required %h", e, {bus.TAP, bus.RISE, bus.FALL, bus.ACTIVE}, {m_tap, m_rise, m_fall, m_act});
      end
    end
  endtask

  task automatic test_inertial();
    flush_all();
    bus.MODE = MODE_INERTIAL;
    for (int e = 1; e <= 40; e++) begin
      bus.IN = {1'b0, (e == 3 || e == 4) ? 1'b1 : 1'b0};
      cyc();
      checks++;
      if (bus.TAP !== '0 || bus.ACTIVE !== '0) begin
        errors++; $display("FAIL inertial_glitch e=%0d tap=%h active=%b required 0", e, bus.TAP, bus.ACTIVE);
      end
    end
    for (int e = 1; e <= 36; e++) begin
      bus.IN = {1'b0, (e >= 2 && e <= 5) ? 1'b1 : 1'b0};
      cyc();
      checks++;
      if (bus.TAP[0] !== (e >= 9 && e <= 12) || bus.TAP[4] !== (e >= 29 && e <= 32)) begin
        errors++; $display("FAIL inertial_pulse e=%0d tap0=%b tap4=%b", e, bus.TAP[0], bus.TAP[4]);
      end
      checks++;
      if ({bus.TAP, bus.RISE, bus.FALL, bus.ACTIVE} !== {m_tap, m_rise, m_fall, m_act}) begin
        errors++; $display("FAIL inertial_model e=%0d got %h required %h", e, {bus.TAP, bus.RISE, bus.FALL, bus.ACTIVE}, {m_tap, m_rise, m_fall, m_act});
      end
    end
    bus.MODE = MODE_TRANSPORT;
  endtask

  task automatic test_freeze();
    int n;
    flush_all();
    n = 0;
    for (int e = 1; e <= 40; e++) begin
      bus.IN = {1'b0, (e <= 3) ? 1'b1 : 1'b0};
      bus.EN = !(e >= 8 && e <= 14);
      if (bus.EN) n++;
      cyc();
      checks++;
      if (bus.TAP[0] !== (n >= 5 && n <= 7) || bus.TAP[2] !== (n >= 15 && n <= 17)) begin
        errors++; $display("FAIL freeze_taps e=%0d tap0=%b tap2=%b", e, bus.TAP[0], bus.TAP[2]);
      end
      if (!bus.EN) begin
        checks++;
        if (bus.RISE !== '0 || bus.FALL !== '0) begin
          errors++; $display("FAIL freeze_strobes e=%0d rise=%h fall=%h required 0", e, bus.RISE, bus.FALL);
        end
      end
      checks++;
      if ({bus.TAP, bus.RISE, bus.FALL, bus.ACTIVE} !== {m_tap, m_rise, m_fall, m_act}) begin
        errors++; $display("FAIL freeze_model e=%0d got %h required %h", e, {bus.TAP, bus.RISE, bus.FALL, bus.ACTIVE}, {m_tap, m_rise, m_fall, m_act});
      end
    end
    bus.EN = 1'b1;
  endtask

  task automatic test_flush();
    flush_all();
    for (int e = 1; e <= 10; e++) begin
      bus.IN = {1'b0, (e <= 6) ? 1'b1 : 1'b0};
      cyc();
    end
    checks++;
    if (bus.ACTIVE[0] !== 1'b1 || bus.TAP[0] !== 1'b1) begin
      errors++; $display("FAIL flush_precondition active0=%b tap0=%b required 1", bus.ACTIVE[0], bus.TAP[0]);
    end
    bus.FLUSH = 1'b1; bus.EN = 1'b1;
    cyc();
    bus.FLUSH = 1'b0;
    checks++;
    if (bus.TAP !== '0 || bus.ACTIVE !== '0 || bus.FALL !== '0 || bus.RISE !== '0) begin
      errors++; $display("FAIL flush_clear tap=%h active=%b fall=%h rise=%h required 0", bus.TAP, bus.ACTIVE, bus.FALL, bus.RISE);
    end
    for (int e = 1; e <= 10; e++) begin
      cyc();
      checks++;
      if ({bus.TAP, bus.RISE, bus.FALL, bus.ACTIVE} !== {m_tap, m_rise, m_fall, m_act}) begin
        errors++; $display("FAIL flush_model e=%0d got %h required %h", e, {bus.TAP, bus.RISE, bus.FALL, bus.ACTIVE}, {m_tap, m_rise, m_fall, m_act});
      end
    end
  endtask

  task automatic test_async_reset();
    flush_all();
    for (int e = 1; e <= 8; e++) begin
      bus.IN = {1'b0, (e <= 6) ? 1'b1 : 1'b0};
      cyc();
    end
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({bus.TAP, bus.RISE, bus.FALL, bus.ACTIVE} !== '0) begin
      errors++; $display("FAIL async_reset_clear got %h required 0", {bus.TAP, bus.RISE, bus.FALL, bus.ACTIVE});
    end
    cyc();
    reset_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      bus.IN = {1'b0, (e >= 2) ? 1'b1 : 1'b0};
      cyc();
      checks++;
      if (bus.TAP[0] !== (e >= 6) || bus.RISE[0] !== (e == 6)) begin
        errors++; $display("FAIL async_reset_fresh e=%0d tap0=%b rise0=%b", e, bus.TAP[0], bus.RISE[0]);
      end
    end
  endtask

  task automatic test_random();
    flush_all();
    for (int e = 1; e <= 600; e++) begin
      for (int c = 0; c < CH; c++) if ($urandom_range(0, 3) == 0) bus.IN[c] = ~bus.IN[c];
      if ($urandom_range(0, 29) == 0) bus.MODE = ~bus.MODE;
      bus.EN    = ($urandom_range(0, 9) != 0);
      bus.FLUSH = ($urandom_range(0, 59) == 0);
      cyc();
      checks++;
      if ({bus.TAP, bus.RISE, bus.FALL, bus.ACTIVE} !== {m_tap, m_rise, m_fall, m_act}) begin
        errors++; $display("FAIL random_model e=%0d got %h required %h", e, {bus.TAP, bus.RISE, bus.FALL, bus.ACTIVE}, {m_tap, m_rise, m_fall, m_act});
      end
    end
    bus.EN = 1'b1; bus.FLUSH = 1'b0; bus.MODE = MODE_TRANSPORT;
  endtask

  task automatic test_min_config();
    logic prev, cur;
    prev = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      cur = e[0];
      bus_m.IN = cur;
      cyc();
      checks++;
      if (bus_m.TAP[0] !== cur || bus_m.RISE[0] !== (cur & ~prev) || bus_m.FALL[0] !== (~cur & prev)) begin
        errors++; $display("FAIL min_toggle e=%0d tap=%b rise=%b fall=%b required tap %b", e, bus_m.TAP[0], bus_m.RISE[0], bus_m.FALL[0], cur);
      end
      prev = cur;
    end
    bus_m.MODE = MODE_INERTIAL;
    for (int e = 1; e <= 10; e++) begin
      cyc();
      checks++;
      if (bus_m.TAP[0] !== 1'b1 || bus_m.RISE[0] !== 1'b0 || bus_m.FALL[0] !== 1'b0) begin
        errors++; $display("FAIL min_mode_switch e=%0d tap=%b rise=%b fall=%b required 1/0/0", e, bus_m.TAP[0], bus_m.RISE[0], bus_m.FALL[0]);
      end
    end
    bus_m.MODE = MODE_TRANSPORT;
  endtask

  initial begin
    test_reset();
    test_transport();
    test_inertial();
    test_freeze();
    test_flush();
    test_async_reset();
    test_random();
    test_min_config();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
